// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: memory modes, access sizes,
// FSM state encodings and a small size-decode helper.
package mem_stage_pkg;

  localparam int ADDR_W = 16;
  localparam int BUS_W  = 8;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BYTE0 = 2'd1;
  localparam logic [1:0] ST_BYTE1 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Only size 2 is a word; every other encoding is treated as a single byte.
  function automatic logic is_word(input logic [1:0] size);
    return size == MEM_SIZE_WORD;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide req/ack data bus between the memory stage (master) and memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic              ack;
  logic [BUS_W-1:0]  rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs 1- or 2-byte reads/writes on the byte bus after the
// ALU and produces the writeback value plus rD/PC write strobes.
// Optional build macro MEM_ALIGN_CHECK_EN: odd-address word accesses skip the
// bus and complete immediately with O_fault.
//
// state | meaning
// IDLE  | waiting for I_enable, inputs latched on enable
// BYTE0 | first (low) byte on the bus at addr, waiting for ack
// BYTE1 | second (high) byte at addr+1, waiting for ack
// DONE  | one-cycle completion: O_done and write strobes
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_enable,
  input  logic [ADDR_W-1:0] I_alu_out,
  input  logic              I_write_rD,
  input  logic              I_write_pc,
  input  logic [1:0]        I_memory_mode,
  input  logic [1:0]        I_memory_size,
  input  logic [ADDR_W-1:0] I_store_data,
  mem_stage_if.master       bus,
  output logic [ADDR_W-1:0] O_result,
  output logic              O_write_rD,
  output logic              O_write_pc,
  output logic              O_done,
  output logic              O_busy,
  output logic              O_fault
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] store_q;
  logic              write_q;
  logic              word_q;
  logic              wr_rd_q;
  logic              wr_pc_q;
  logic [BUS_W-1:0]  rd_lo_q;
  logic [ADDR_W-1:0] result_q;
  logic              in_done;
  logic              in_bus;

`ifdef MEM_ALIGN_CHECK_EN
  logic              fault_q;
`endif

  // FSM and datapath registers; result is loaded on every entry into DONE so it
  // holds until the next completion.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      write_q  <= 1'b0;
      word_q   <= 1'b0;
      wr_rd_q  <= 1'b0;
      wr_pc_q  <= 1'b0;
      rd_lo_q  <= '0;
      result_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_enable) begin
            addr_q  <= I_alu_out;
            store_q <= I_store_data;
            write_q <= (I_memory_mode == MEM_WRITE);
            word_q  <= is_word(I_memory_size);
            wr_rd_q <= I_write_rD;
            wr_pc_q <= I_write_pc;
`ifdef MEM_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
            if (I_memory_mode == MEM_NOP) begin
              result_q <= I_alu_out;
              state    <= ST_DONE;
`ifdef MEM_ALIGN_CHECK_EN
            end else if (is_word(I_memory_size) && I_alu_out[0]) begin
              // Misaligned word: report the address, suppress all writeback.
              result_q <= I_alu_out;
              fault_q  <= 1'b1;
              wr_rd_q  <= 1'b0;
              wr_pc_q  <= 1'b0;
              state    <= ST_DONE;
`endif
            end else begin
              state <= ST_BYTE0;
            end
          end
        end
        ST_BYTE0: begin
          if (bus.ack) begin
            rd_lo_q <= bus.rdata;
            if (word_q) begin
              state <= ST_BYTE1;
            end else begin
              result_q <= write_q ? addr_q : {{(ADDR_W-BUS_W){1'b0}}, bus.rdata};
              state    <= ST_DONE;
            end
          end
        end
        ST_BYTE1: begin
          if (bus.ack) begin
            result_q <= write_q ? addr_q : {bus.rdata, rd_lo_q};
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus and status outputs decode straight from registered state, so they stay
  // stable for the whole time a byte waits for ack.
  always_comb begin
    in_done   = (state == ST_DONE);
    in_bus    = (state == ST_BYTE0) || (state == ST_BYTE1);
    bus.req   = in_bus;
    bus.we    = in_bus & write_q;
    bus.addr  = '0;
    bus.wdata = '0;
    if (state == ST_BYTE0) begin
      bus.addr  = addr_q;
      bus.wdata = store_q[BUS_W-1:0];
    end else if (state == ST_BYTE1) begin
      bus.addr  = addr_q + ADDR_W'(1);
      bus.wdata = store_q[ADDR_W-1:BUS_W];
    end
    O_result   = result_q;
    O_done     = in_done;
    O_write_rD = in_done & wr_rd_q;
    O_write_pc = in_done & wr_pc_q;
    O_busy     = (state != ST_IDLE);
`ifdef MEM_ALIGN_CHECK_EN
    O_fault    = in_done & fault_q;
`else
    O_fault    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage; each task drives one scenario and checks
// outputs 1 time unit after the rising edge.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] alu_out;
  logic        write_rD;
  logic        write_pc;
  logic [1:0]  mode;
  logic [1:0]  size;
  logic [15:0] store;
  logic [15:0] result;
  logic        o_write_rD;
  logic        o_write_pc;
  logic        done;
  logic        busy;
  logic        fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .I_clk         (clk),
    .I_reset       (rst),
    .I_enable      (enable),
    .I_alu_out     (alu_out),
    .I_write_rD    (write_rD),
    .I_write_pc    (write_pc),
    .I_memory_mode (mode),
    .I_memory_size (size),
    .I_store_data  (store),
    .bus           (bus),
    .O_result      (result),
    .O_write_rD    (o_write_rD),
    .O_write_pc    (o_write_pc),
    .O_done        (done),
    .O_busy        (busy),
    .O_fault       (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse I_enable for one cycle; returns 1 unit after the edge that latched it.
  task automatic start(input logic [1:0] m, input logic [1:0] s, input logic [15:0] a,
                       input logic [15:0] st, input logic rd, input logic pc);
    mode = m; size = s; alu_out = a; store = st; write_rD = rd; write_pc = pc;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.req, bus.we, bus.addr, bus.wdata, result, o_write_rD, o_write_pc, done, busy, fault} !== 45'd0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h result=%h rD=%b pc=%b done=%b busy=%b fault=%b, all required 0",
               bus.req, bus.we, bus.addr, bus.wdata, result, o_write_rD, o_write_pc, done, busy, fault);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nop();
    start(MEM_NOP, MEM_SIZE_BYTE, 16'h1234, 16'h0000, 1'b1, 1'b0);
    tests++;
    if ({done, o_write_rD, o_write_pc, bus.req, fault} !== 5'b11000) begin
      fails++;
      $display("FAIL nop_strobes: done,rD,pc,req,fault=%b required 11000", {done, o_write_rD, o_write_pc, bus.req, fault});
    end
    tests++;
    if (result !== 16'h1234) begin
      fails++;
      $display("FAIL nop_result: got %h required 1234", result);
    end
    tick();
    tests++;
    if ({done, busy, o_write_rD} !== 3'b000) begin
      fails++;
      $display("FAIL nop_after: done,busy,rD=%b required 000", {done, busy, o_write_rD});
    end
  endtask

  task automatic test_byte_read();
    start(MEM_READ, MEM_SIZE_BYTE, 16'h0040, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({bus.req, bus.we, busy, done} !== 4'b1010 || bus.addr !== 16'h0040) begin
        fails++;
        $display("FAIL byte_read_wait%0d: req,we,busy,done=%b addr=%h required 1010 addr 0040",
                 i, {bus.req, bus.we, busy, done}, bus.addr);
      end
      tick();
    end
    bus.ack = 1'b1; bus.rdata = 8'hA5;
    tick();
    bus.ack = 1'b0; bus.rdata = 8'h00;
    tests++;
    if ({done, o_write_rD, o_write_pc, bus.req} !== 4'b1100) begin
      fails++;
      $display("FAIL byte_read_done: done,rD,pc,req=%b required 1100", {done, o_write_rD, o_write_pc, bus.req});
    end
    tests++;
    if (result !== 16'h00A5) begin
      fails++;
      $display("FAIL byte_read_result: got %h required 00a5", result);
    end
    tick();
  endtask

  task automatic test_word_write();
    start(MEM_WRITE, MEM_SIZE_WORD, 16'h00FE, 16'hBEEF, 1'b0, 1'b0);
    tests++;
    if ({bus.req, bus.we} !== 2'b11 || bus.addr !== 16'h00FE || bus.wdata !== 8'hEF) begin
      fails++;
      $display("FAIL word_write_b0: req,we=%b addr=%h wdata=%h required 11 00fe ef", {bus.req, bus.we}, bus.addr, bus.wdata);
    end
    bus.ack = 1'b1;
    tick();
    tests++;
    if ({bus.req, bus.we} !== 2'b11 || bus.addr !== 16'h00FF || bus.wdata !== 8'hBE || done !== 1'b0) begin
      fails++;
      $display("FAIL word_write_b1: req,we=%b addr=%h wdata=%h done=%b required 11 00ff be 0",
               {bus.req, bus.we}, bus.addr, bus.wdata, done);
    end
    tick();
    bus.ack = 1'b0;
    tests++;
    if ({done, bus.req, o_write_rD} !== 3'b100 || result !== 16'h00FE) begin
      fails++;
      $display("FAIL word_write_done: done,req,rD=%b result=%h required 100 00fe", {done, bus.req, o_write_rD}, result);
    end
    tick();
  endtask

  task automatic test_word_read_wrap();
    start(MEM_READ, MEM_SIZE_WORD, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    tests++;
    if ({done, fault, bus.req, o_write_rD, o_write_pc} !== 5'b11000 || result !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_fault: done,fault,req,rD,pc=%b result=%h required 11000 ffff",
               {done, fault, bus.req, o_write_rD, o_write_pc}, result);
    end
`else
    tests++;
    if (bus.req !== 1'b1 || bus.addr !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_b0: req=%b addr=%h required 1 ffff", bus.req, bus.addr);
    end
    bus.ack = 1'b1; bus.rdata = 8'h34;
    tick();
    tests++;
    if (bus.req !== 1'b1 || bus.addr !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_b1: req=%b addr=%h required 1 0000", bus.req, bus.addr);
    end
    bus.rdata = 8'h12;
    tick();
    bus.ack = 1'b0; bus.rdata = 8'h00;
    tests++;
    if ({done, fault, o_write_rD} !== 3'b101 || result !== 16'h1234) begin
      fails++;
      $display("FAIL wrap_done: done,fault,rD=%b result=%h required 101 1234", {done, fault, o_write_rD}, result);
    end
`endif
    tick();
  endtask

  task automatic test_irq_return();
    start(MEM_READ, MEM_SIZE_WORD, 16'h0100, 16'h0000, 1'b1, 1'b1);
    tick();
    bus.ack = 1'b1; bus.rdata = 8'h78;
    tick();
    tests++;
    if (bus.addr !== 16'h0101 || done !== 1'b0) begin
      fails++;
      $display("FAIL irq_b1: addr=%h done=%b required 0101 0", bus.addr, done);
    end
    bus.rdata = 8'h56;
    tick();
    bus.ack = 1'b0;
    tests++;
    if ({done, o_write_rD, o_write_pc} !== 3'b111 || result !== 16'h5678) begin
      fails++;
      $display("FAIL irq_done: done,rD,pc=%b result=%h required 111 5678", {done, o_write_rD, o_write_pc}, result);
    end
    tick();
    tests++;
    if ({done, o_write_rD, o_write_pc} !== 3'b000 || result !== 16'h5678) begin
      fails++;
      $display("FAIL irq_after: done,rD,pc=%b result=%h required 000 5678", {done, o_write_rD, o_write_pc}, result);
    end
  endtask

  task automatic test_reset_mid();
    start(MEM_READ, MEM_SIZE_WORD, 16'h0010, 16'h0000, 1'b1, 1'b1);
    bus.ack = 1'b1; bus.rdata = 8'h11;
    tick();
    bus.ack = 1'b0;
    tests++;
    if (bus.req !== 1'b1 || bus.addr !== 16'h0011) begin
      fails++;
      $display("FAIL rstmid_b1: req=%b addr=%h required 1 0011", bus.req, bus.addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({bus.req, done, o_write_rD, o_write_pc, busy} !== 5'b00000) begin
        fails++;
        $display("FAIL rstmid_after%0d: req,done,rD,pc,busy=%b required 00000", i, {bus.req, done, o_write_rD, o_write_pc, busy});
      end
      tick();
    end
  endtask

  task automatic test_enable_busy();
    start(MEM_READ, MEM_SIZE_BYTE, 16'h0020, 16'h0000, 1'b1, 1'b0);
    start(MEM_NOP, MEM_SIZE_BYTE, 16'h9999, 16'h0000, 1'b0, 1'b1);
    tests++;
    if ({bus.req, done} !== 2'b10 || bus.addr !== 16'h0020) begin
      fails++;
      $display("FAIL busy_ignore: req,done=%b addr=%h required 10 0020", {bus.req, done}, bus.addr);
    end
    bus.ack = 1'b1; bus.rdata = 8'h5A;
    tick();
    bus.ack = 1'b0;
    tests++;
    if ({done, o_write_rD, o_write_pc} !== 3'b110 || result !== 16'h005A) begin
      fails++;
      $display("FAIL busy_done: done,rD,pc=%b result=%h required 110 005a", {done, o_write_rD, o_write_pc}, result);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({bus.req, done, busy} !== 3'b000) begin
        fails++;
        $display("FAIL busy_no_second%0d: req,done,busy=%b required 000", i, {bus.req, done, busy});
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; alu_out = '0; write_rD = 1'b0; write_pc = 1'b0;
    mode = MEM_NOP; size = MEM_SIZE_BYTE; store = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    test_reset();
    test_nop();
    test_byte_read();
    test_word_write();
    test_word_read_wrap();
    test_irq_return();
    test_reset_mid();
    test_enable_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
